assoc_store: RTL
================

# assoc_store

Parametrised, synthesizable fully-associative key/value store: the hardware successor to the behavioural 64-bit associative memory model. It is used behind the same traffic generator and in RTL wherever a sparse address space must be backed by a small table. It adds a valid/ready request/response handshake, delete and clear operations, hit/miss status, an occupancy count and round-robin eviction when full. Unwritten keys read as `DEFAULT_VAL`, matching associative-array semantics.

## Interface
- `ADDR_W`, 64: key width.
- `DATA_W`, 64: value width.
- `DEPTH`, 16: number of entries; must be ≥2.
- `DEFAULT_VAL`, '0: data returned on a read miss.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: store can accept a request.
- `req_op` in 2: operation; 0 READ, 1 WRITE, 2 DELETE, 3 CLEAR.
- `req_addr` in ADDR_W: key.
- `req_wdata` in DATA_W: write value.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_hit` out 1: key was present at lookup.
- `rsp_evict` out 1: a WRITE displaced another entry.
- `rsp_rdata` out DATA_W: return data for the operation (see Operation).
- `count` out $clog2(DEPTH+1): number of valid entries.

## Operation
- Each entry holds {valid, key, data}. Entries are compared in parallel.
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, capture op/addr/wdata and go to LOOKUP.
  - LOOKUP: register the hit flag, hit index, first-free index (lowest index) and full flag.
  - EXEC: apply the operation and load the response registers. Go to RESP.
  - RESP: `rsp_valid`=1; hold all response outputs stable until `rsp_ready`, then go to IDLE.
- Operations:
  - READ: hit → `rsp_rdata`=entry data. Miss → `rsp_rdata`=DEFAULT_VAL. No state change.
  - WRITE hit: overwrite data; `rsp_rdata`=old data.
  - WRITE miss, not full: allocate the lowest free entry; `count`+1.
  - WRITE miss, full: replace the entry at `victim_ptr`; `rsp_evict`=1; `rsp_rdata`=evicted data. `victim_ptr` advances modulo DEPTH (wraps DEPTH-1→0).
  - DELETE: hit → invalidate, `count`−1, `rsp_rdata`=old data. Miss → no change, `rsp_rdata`=DEFAULT_VAL.
  - CLEAR: invalidate all entries, `count`=0, `victim_ptr`=0, `rsp_hit`=0, `rsp_rdata`=DEFAULT_VAL.
- Keys are unique; a key is never held twice.
- `victim_ptr` changes only on an eviction or on CLEAR.
- In all cases not listed above, `rsp_evict`=0.

## Timing
- Request accepted at edge T; `rsp_valid` rises after edge T+3; earliest next accept is at edge T+5. One request is outstanding at a time.
- `req_ready`=0 in LOOKUP, EXEC and RESP.
- Backpressure: `rsp_valid` with `rsp_ready`=0 holds indefinitely with all response outputs unchanged.
- `count` updates at the EXEC edge, visible together with `rsp_valid`.
- Reset values (any cycle, including mid-operation): state IDLE, `req_ready`=1 after reset, `rsp_valid`=0, `rsp_hit`=0, `rsp_evict`=0, `rsp_rdata`=0, `count`=0, all entries invalid, `victim_ptr`=0. An in-flight request is dropped and produces no response.
- Data storage is not reset; only valid bits are.

## Configuration
- `ASSOC_STORE_STATS_EN` defined: adds outputs `stat_hits` (32 bit), `stat_misses` (32 bit) and `stat_evicts` (32 bit).
  - `stat_hits`/`stat_misses` count READ/WRITE/DELETE lookups at EXEC; `stat_evicts` counts evictions.
  - Counters saturate at all-ones, reset to 0, and are cleared by CLEAR.
- Not defined: the ports and counters do not exist; all other behaviour is identical.

## Structure
- Package `assoc_store_pkg`:
  - `op_e` enum (OP_READ, OP_WRITE, OP_DELETE, OP_CLEAR).
  - `state_e` enum (IDLE, LOOKUP, EXEC, RESP).
  - Entry struct type parametrised by the module via local typedef.
- Sub-module `assoc_store_match`: purely combinational. It takes the valid vector, keys and lookup key, and returns hit, hit_idx, free_idx and full. Priority is lowest index.
- Top module holds the FSM, entry array, victim pointer, count and optional stats.

## Test plan
- Reset, then READ 0x1000 → `rsp_hit`=0, `rsp_rdata`=0, `count`=0; `rsp_valid` appears 3 cycles after accept.
- WRITE 0x1000=0xAA, then READ 0x1000 → hit=1, data 0xAA. WRITE 0x1000=0xBB → hit=1, `rsp_rdata`=0xAA, `count`=1.
- DEPTH=4: WRITE keys 1..4, then WRITE key 5 → evict=1, `rsp_rdata`=data of key 1; then WRITE keys 6, 7, 8, 9 → `victim_ptr` wraps 3→0; READ key 5 → miss.
- DELETE key 2 with table full → `count`=3; next new WRITE fills entry 1 with no eviction.
- Hold `rsp_ready`=0 for 10 cycles → outputs stable, `req_ready`=0; assert `rst_n`=0 mid-LOOKUP → no response, `count`=0.
- With `ASSOC_STORE_STATS_EN`: 3 hits, 2 misses, 1 eviction → counters read 3/2/1; CLEAR → 0/0/0.

Source files
------------

// File: rtl/assoc_store_pkg.sv
// assoc_store_pkg: shared opcode/state enums and helpers for the associative store.
// Entry layout is parametric, so the entry struct is typedef'd locally in the top.
// Optional statistics (ASSOC_STORE_STATS_EN) use STAT_W-wide saturating counters.
package assoc_store_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_DELETE = 2'd2,
    OP_CLEAR  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    EXEC   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int STAT_W = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/assoc_store_match.sv
// assoc_store_match: parallel key compare plus free-slot search over all entries.
// Latency: purely combinational; results are registered by the caller.
// Backpressure: none; lowest index wins for both hit and free-slot selection.
module assoc_store_match
  import assoc_store_pkg::*;
#(
  parameter  int ADDR_W = 64,
  parameter  int DEPTH  = 16,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] keys,
  input  logic [ADDR_W-1:0]            key,
  output logic                         hit,
  output logic [IDX_W-1:0]             hit_idx,
  output logic [IDX_W-1:0]             free_idx,
  output logic                         full
);

  // Scan high to low so the lowest matching / free index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    full     = &valid;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && (keys[i] == key)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/assoc_store.sv
// assoc_store: fully-associative key/value table with read/write/delete/clear and round-robin eviction.
// Latency: accept at edge T, rsp_valid after edge T+3, next accept at edge T+5 at the earliest.
// Backpressure: rsp_valid and all response fields hold until rsp_ready; req_ready low while busy.
// Optional statistics counters are enabled with `define ASSOC_STORE_STATS_EN.
module assoc_store
  import assoc_store_pkg::*;
#(
  parameter int              ADDR_W      = 64,
  parameter int              DATA_W      = 64,
  parameter int              DEPTH       = 16,
  parameter logic [DATA_W-1:0] DEFAULT_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_op,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_hit,
  output logic                         rsp_evict,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef ASSOC_STORE_STATS_EN
  ,
  output logic [STAT_W-1:0]            stat_hits,
  output logic [STAT_W-1:0]            stat_misses,
  output logic [STAT_W-1:0]            stat_evicts
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  // Key/data payload; the valid bits live in a separate vector because they
  // alone are reset, the payload is not.
  typedef struct packed {
    logic [ADDR_W-1:0] key;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e                      state, state_nxt;
  op_e                         op_q;
  logic [ADDR_W-1:0]           addr_q;
  logic [DATA_W-1:0]           wdata_q;

  entry_t                      ent [DEPTH];
  logic [DEPTH-1:0]            ent_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_keys;

  logic                        m_hit, m_full;
  logic [IDX_W-1:0]            m_hit_idx, m_free_idx;
  logic                        hit_q, full_q;
  logic [IDX_W-1:0]            hit_idx_q, free_idx_q;

  logic [IDX_W-1:0]            victim_ptr;
  logic [IDX_W-1:0]            tgt_idx;
  logic [DATA_W-1:0]           old_data;
  logic                        do_evict;

  // Flatten stored keys for the matcher.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_keys[i] = ent[i].key;
    end
  end

  assoc_store_match #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_match (
    .valid    (ent_vld),
    .keys     (ent_keys),
    .key      (addr_q),
    .hit      (m_hit),
    .hit_idx  (m_hit_idx),
    .free_idx (m_free_idx),
    .full     (m_full)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic; RESP leaves only once the consumer has taken the response.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)              state_nxt = LOOKUP;
      LOOKUP:                              state_nxt = EXEC;
      EXEC:                                state_nxt = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_ready = (state == IDLE);
  end

  // Capture the accepted request.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      op_q    <= op_e'(req_op);
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Register the lookup results so EXEC works from stable flops.
  always_ff @(posedge clk) begin
    if (state == LOOKUP) begin
      hit_q      <= m_hit;
      hit_idx_q  <= m_hit_idx;
      free_idx_q <= m_free_idx;
      full_q     <= m_full;
    end
  end

  // Entry touched by the operation: the hit, else a free slot, else the victim.
  always_comb begin
    tgt_idx  = hit_q ? hit_idx_q : (full_q ? victim_ptr : free_idx_q);
    old_data = ent[tgt_idx].data;
    do_evict = (op_q == OP_WRITE) && !hit_q && full_q;
  end

  // Payload storage, written on WRITE only; deliberately not reset.
  always_ff @(posedge clk) begin
    if (state == EXEC && op_q == OP_WRITE) begin
      ent[tgt_idx] <= '{key: addr_q, data: wdata_q};
    end
  end

  // Valid bits, occupancy count and eviction pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_vld    <= '0;
      count      <= '0;
      victim_ptr <= '0;
    end else if (state == EXEC) begin
      case (op_q)
        OP_WRITE: begin
          ent_vld[tgt_idx] <= 1'b1;
          if (!hit_q && !full_q) count <= count + 1'b1;
          if (do_evict) begin
            victim_ptr <= (victim_ptr == IDX_W'(DEPTH - 1)) ? '0 : victim_ptr + 1'b1;
          end
        end
        OP_DELETE: begin
          if (hit_q) begin
            ent_vld[hit_idx_q] <= 1'b0;
            count              <= count - 1'b1;
          end
        end
        OP_CLEAR: begin
          ent_vld    <= '0;
          count      <= '0;
          victim_ptr <= '0;
        end
        default: ;
      endcase
    end
  end

  // Response fields load at EXEC; rsp_valid launches from a flop one cycle into RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_evict <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (state == EXEC) begin
        rsp_hit   <= (op_q != OP_CLEAR) && hit_q;
        rsp_evict <= do_evict;
        case (op_q)
          OP_READ:   rsp_rdata <= hit_q ? old_data : DEFAULT_VAL;
          OP_WRITE:  rsp_rdata <= (hit_q || full_q) ? old_data : DEFAULT_VAL;
          OP_DELETE: rsp_rdata <= hit_q ? old_data : DEFAULT_VAL;
          default:   rsp_rdata <= DEFAULT_VAL;
        endcase
      end
      if (state == RESP && !rsp_valid) begin
        rsp_valid <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ASSOC_STORE_STATS_EN
  // Saturating lookup/eviction statistics, zeroed by reset and by CLEAR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_evicts <= '0;
    end else if (state == EXEC) begin
      if (op_q == OP_CLEAR) begin
        stat_hits   <= '0;
        stat_misses <= '0;
        stat_evicts <= '0;
      end else begin
        if (hit_q) stat_hits   <= sat_inc(stat_hits);
        else       stat_misses <= sat_inc(stat_misses);
        if (do_evict) stat_evicts <= sat_inc(stat_evicts);
      end
    end
  end
`endif

endmodule
